// File: rtl/sh_ram_writer_if.sv
// sh_ram_writer_if: request/acknowledge and sh_ram write-port bundle for the
// sh_ram write-side controller.
//
// Handshake: each source raises *_req with *_val stable and holds both until it
// sees a one-cycle *_ack; *_val is captured on the edge that raises *_ack, and
// the source drops *_req in the following cycle. The write port has no back
// pressure: every cycle with wr_en=1 commits wr_data to sh_ram[wr_addr].
//
// Signals:
//   spd_req/spd_val/spd_ack  speed source handshake
//   dst_req/dst_val/dst_ack  distance source handshake
//   wr_en/wr_addr/wr_data    sh_ram write port (registered)
//   busy                     controller not in IDLE
//   state_dbg                controller FSM state (debug)
// Modports: master = the controller, slave = sources + sh_ram side.
interface sh_ram_writer_if #(
    parameter int DATA_W = 17
);
    logic              spd_req;
    logic [DATA_W-1:0] spd_val;
    logic              spd_ack;
    logic              dst_req;
    logic [DATA_W-1:0] dst_val;
    logic              dst_ack;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [3:0]        wr_data;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        input  spd_req, spd_val, dst_req, dst_val,
        output spd_ack, dst_ack, wr_en, wr_addr, wr_data, busy, state_dbg
    );

    modport slave (
        output spd_req, spd_val, dst_req, dst_val,
        input  spd_ack, dst_ack, wr_en, wr_addr, wr_data, busy, state_dbg
    );
endinterface

// File: rtl/sh_ram_writer.sv
// sh_ram_writer: write-side controller of the 10-entry digit RAM.
// Arbitrates round-robin between the speed and distance sources, saturates the
// granted value to 99999, converts it to five BCD digits (double-dabble, one
// shift per cycle) and writes them MS digit first into the source's group:
// distance -> addr 0..4, speed -> addr 5..9.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sh_ram_writer_if.master (requests, acks, sh_ram write port, busy, state)
//
// Optional build macro SH_RAM_BLANK_EN: leading zero digits of a group are
// written as 4'hF; the units digit is always numeric.
module sh_ram_writer #(
    parameter int DATA_W = 17
) (
    input  logic            clk,
    input  logic            rst,
    sh_ram_writer_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam int              CONV_W   = 17;
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(99999);
    localparam logic [3:0]      BLANK    = 4'hF;
    localparam logic [3:0]      DST_BASE = 4'd0;
    localparam logic [3:0]      SPD_BASE = 4'd5;

`ifdef SH_RAM_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [CONV_W-1:0] bin_q, bin_d;
    logic [19:0]       bcd_q, bcd_d;
    logic              grp_spd_q, grp_spd_d;
    logic              last_spd_q, last_spd_d;   // 0 = distance granted last
    logic              lead_q, lead_d;           // all digits so far were blanked
    logic              spd_ack_q, spd_ack_d;
    logic              dst_ack_q, dst_ack_d;
    logic              wr_en_q, wr_en_d;
    logic [3:0]        wr_addr_q, wr_addr_d;
    logic [3:0]        wr_data_q, wr_data_d;

    logic              grant_spd, grant_dst;
    logic [19:0]       bcd_adj, bcd_step;
    logic [CONV_W-1:0] bin_step;
    logic [19:0]       emit_bcd;
    logic [2:0]        emit_idx;
    logic              emit_lead, emit_blank;
    logic [3:0]        emit_raw, emit_data, emit_addr;

    function automatic logic [DATA_W-1:0] sat(input logic [DATA_W-1:0] v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    function automatic logic [3:0] digit_at(input logic [19:0] bcd, input logic [2:0] k);
        case (k)
            3'd0:    return bcd[19:16];
            3'd1:    return bcd[15:12];
            3'd2:    return bcd[11:8];
            3'd3:    return bcd[7:4];
            default: return bcd[3:0];
        endcase
    endfunction

    // On a tie the source not granted last time wins.
    assign grant_spd = bus.spd_req && (!bus.dst_req || !last_spd_q);
    assign grant_dst = bus.dst_req && !grant_spd;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
        {bcd_step, bin_step} = {bcd_adj[18:0], bin_q, 1'b0};
    end

    // Digit emission. The last conversion edge already emits digit 0, so it
    // takes the freshly shifted BCD value instead of the stored one.
    always_comb begin
        emit_bcd   = (state_q == S_CONV) ? bcd_step : bcd_q;
        emit_idx   = (state_q == S_CONV) ? 3'd0 : cnt_q[2:0];
        emit_lead  = (state_q == S_CONV) ? 1'b1 : lead_q;
        emit_raw   = digit_at(emit_bcd, emit_idx);
        emit_blank = BLANK_EN && emit_lead && (emit_raw == 4'd0) && (emit_idx != 3'd4);
        emit_data  = emit_blank ? BLANK : emit_raw;
        emit_addr  = (grp_spd_q ? SPD_BASE : DST_BASE) + {1'b0, emit_idx};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        grp_spd_d  = grp_spd_q;
        last_spd_d = last_spd_q;
        lead_d     = lead_q;
        spd_ack_d  = 1'b0;
        dst_ack_d  = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = 4'd0;
        wr_data_d  = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (grant_spd || grant_dst) begin
                    state_d    = S_CONV;
                    cnt_d      = 5'd0;
                    bcd_d      = 20'd0;
                    bin_d      = CONV_W'(grant_spd ? sat(bus.spd_val) : sat(bus.dst_val));
                    grp_spd_d  = grant_spd;
                    last_spd_d = grant_spd;
                    spd_ack_d  = grant_spd;
                    dst_ack_d  = grant_dst;
                end
            end
            S_CONV: begin
                bcd_d = bcd_step;
                bin_d = bin_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(CONV_W - 1)) begin
                    state_d   = S_WRITE;
                    cnt_d     = 5'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = emit_addr;
                    wr_data_d = emit_data;
                    lead_d    = emit_blank;
                end
            end
            S_WRITE: begin
                if (cnt_q == 5'd5) begin
                    state_d = S_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = emit_addr;
                    wr_data_d = emit_data;
                    lead_d    = emit_blank;
                    cnt_d     = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            bin_q      <= '0;
            bcd_q      <= 20'd0;
            grp_spd_q  <= 1'b0;
            last_spd_q <= 1'b0;
            lead_q     <= 1'b0;
            spd_ack_q  <= 1'b0;
            dst_ack_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 4'd0;
            wr_data_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            grp_spd_q  <= grp_spd_d;
            last_spd_q <= last_spd_d;
            lead_q     <= lead_d;
            spd_ack_q  <= spd_ack_d;
            dst_ack_q  <= dst_ack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.spd_ack   = spd_ack_q;
    assign bus.dst_ack   = dst_ack_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_sh_ram_writer.sv
// Bench for sh_ram_writer: request drivers feed a reference model that pushes
// the expected sh_ram writes (cycle, address, digit) into exp_q; an independent
// monitor pops and compares on every wr_en cycle.
module tb_sh_ram_writer;
    localparam int DATA_W = 17;

`ifdef SH_RAM_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   model_last_spd = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;

    sh_ram_writer_if #(.DATA_W(DATA_W)) bus ();

    sh_ram_writer #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Digit k (0 = ten-thousands) of the saturated value, from plain decimal arithmetic.
    function automatic logic [3:0] ref_digit(input int v, input int k);
        int sv;
        int p;
        sv = (v > 99999) ? 99999 : v;
        p = 1;
        for (int i = 0; i < 4 - k; i++) p = p * 10;
        if (BLANK_EN && k < 4 && sv < p) return 4'hF;
        return 4'((sv / p) % 10);
    endfunction

    task automatic push_writes(input bit is_spd, input int v, input int g);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({32'(g + 17 + k), 4'((is_spd ? 5 : 0) + k), ref_digit(v, k)});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_write: addr %0d data %0d, no write expected (cycle %0d)",
                             bus.wr_addr, bus.wr_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_cycle", cyc, int'(mon_e[39:8]));
                    check("wr_addr", int'(bus.wr_addr), int'(mon_e[7:4]));
                    check("wr_data", int'(bus.wr_data), int'(mon_e[3:0]));
                end
            end else begin
                check("idle_wr_addr", int'(bus.wr_addr), 0);
                check("idle_wr_data", int'(bus.wr_data), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_ack(input bit is_spd, input int v, input int exp_g, output int g);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        g = -1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = bus.spd_ack || bus.dst_ack;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within 40 cycles, expected %s", is_spd ? "spd" : "dst");
            if (is_spd) bus.spd_req = 1'b0; else bus.dst_req = 1'b0;
            return;
        end
        g = cyc;
        check(is_spd ? "spd_ack" : "dst_ack", int'(is_spd ? bus.spd_ack : bus.dst_ack), 1);
        check("other_ack", int'(is_spd ? bus.dst_ack : bus.spd_ack), 0);
        check("ack_cycle", g, exp_g);
        check("busy_c1", int'(bus.busy), 1);
        push_writes(is_spd, v, g);
        model_last_spd = is_spd;
        @(negedge clk);
        check("ack_one_cycle", int'({bus.spd_ack, bus.dst_ack}), 0);
        if (is_spd) bus.spd_req = 1'b0; else bus.dst_req = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_low_cycle", cyc, g + 22);
    endtask

    task automatic single(input bit is_spd, input int v);
        int c;
        int g;
        @(negedge clk);
        c = cyc;
        if (is_spd) begin
            bus.spd_val = DATA_W'(v);
            bus.spd_req = 1'b1;
        end else begin
            bus.dst_val = DATA_W'(v);
            bus.dst_req = 1'b1;
        end
        expect_ack(is_spd, v, c + 1, g);
        wait_done(g);
    endtask

    task automatic tie(input int vs, input int vd);
        int c;
        int g;
        int g2;
        bit w;
        @(negedge clk);
        c = cyc;
        bus.spd_val = DATA_W'(vs);
        bus.dst_val = DATA_W'(vd);
        bus.spd_req = 1'b1;
        bus.dst_req = 1'b1;
        w = !model_last_spd;
        expect_ack(w, w ? vs : vd, c + 1, g);
        expect_ack(!w, w ? vd : vs, g + 23, g2);
        wait_done(g2);
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_spd_ack"}, int'(bus.spd_ack), 0);
        check({tag, "_dst_ack"}, int'(bus.dst_ack), 0);
        check({tag, "_wr_en"}, int'(bus.wr_en), 0);
        check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        check({tag, "_wr_data"}, int'(bus.wr_data), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        check_reset_outputs(tag);
        exp_q.delete();
        model_last_spd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int g;
        int g2;
        int vs;
        int vd;
        rst = 1'b1;
        bus.spd_req = 1'b0;
        bus.dst_req = 1'b0;
        bus.spd_val = '0;
        bus.dst_val = '0;
        check_reset_outputs("reset_init");

        // Both sources requesting straight out of reset: speed wins the first tie.
        vs = int'($urandom_range(0, 131071));
        vd = int'($urandom_range(0, 131071));
        bus.spd_val = DATA_W'(vs);
        bus.dst_val = DATA_W'(vd);
        bus.spd_req = 1'b1;
        bus.dst_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        c = cyc;
        rst = 1'b0;
        expect_ack(1'b1, vs, c + 1, g);
        expect_ack(1'b0, vd, g + 23, g2);
        wait_done(g2);
        tie(int'($urandom_range(0, 99999)), int'($urandom_range(0, 99999)));

        // Directed values: typical, saturation, boundary, zero, blanking patterns.
        single(1'b1, 345);
        single(1'b0, 123456);
        single(1'b0, 99999);
        single(1'b0, 0);
        single(1'b0, 100000);
        single(1'b1, 131071);
        single(1'b1, 7);
        single(1'b1, 0);
        single(1'b1, 10203);
        single(1'b0, 9);

        // Speed request rising during a distance conversion stays pending.
        @(negedge clk);
        c = cyc;
        vd = int'($urandom_range(0, 131071));
        vs = int'($urandom_range(0, 131071));
        bus.dst_val = DATA_W'(vd);
        bus.dst_req = 1'b1;
        expect_ack(1'b0, vd, c + 1, g);
        repeat (3) @(negedge clk);
        bus.spd_val = DATA_W'(vs);
        bus.spd_req = 1'b1;
        expect_ack(1'b1, vs, g + 23, g2);
        wait_done(g2);

        // Randomized mix of single requests and ties.
        for (int i = 0; i < 20; i++) begin
            vs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 131071));
            vd = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 131071));
            case ($urandom_range(0, 2))
                0:       single(1'b1, vs);
                1:       single(1'b0, vd);
                default: tie(vs, vd);
            endcase
        end

        // Reset while idle.
        @(negedge clk);
        pulse_reset("reset_idle");
        repeat (5) @(negedge clk);

        // Reset mid-conversion: the aborted update must produce no writes.
        @(negedge clk);
        c = cyc;
        bus.spd_val = DATA_W'(12345);
        bus.spd_req = 1'b1;
        expect_ack(1'b1, 12345, c + 1, g);
        repeat (5) @(negedge clk);
        pulse_reset("reset_conv");
        repeat (30) @(negedge clk);

        // last_grant was cleared by reset, so speed wins this tie again.
        tie(int'($urandom_range(0, 131071)), int'($urandom_range(0, 131071)));

        repeat (5) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sh_ram_writer.md
# sh_ram_writer

Write-side controller for the 10-entry digit RAM (sh_ram) scanned by the display column mapper. It arbitrates between two value sources, the speed requester and the distance requester. It converts the granted binary value to five BCD digits and writes them into that source's half of sh_ram, one digit per cycle. The display read path is untouched; this block owns the sh_ram write port exclusively.

## Interface
- DATA_W, 17, width of source values (max representable 131071; display range 0–99999)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- spd_req  input  1  speed update request; level, held until spd_ack
- spd_val  input  DATA_W  speed value; stable while spd_req high
- spd_ack  output  1  one-cycle grant/capture acknowledge for speed
- dst_req  input  1  distance update request; level, held until dst_ack
- dst_val  input  DATA_W  distance value; stable while dst_req high
- dst_ack  output  1  one-cycle grant/capture acknowledge for distance
- wr_en  output  1  sh_ram write strobe
- wr_addr  output  4  sh_ram address 0–9
- wr_data  output  4  digit code (0–9, or 4'hF blank)
- busy  output  1  high in any state other than IDLE

## Operation
- Address map: distance uses addr 0–4, speed uses addr 5–9. Within a group, the lowest address is the most significant digit (base+0 = ten-thousands, base+4 = units).
- FSM states:
  - IDLE: req sampled here only. On any req, grant, capture the value and go to CONV.
  - CONV: double-dabble. 17 iterations; each adds 3 to every BCD nibble ≥5, then shifts left 1 bit. Go to WRITE after iteration 17.
  - WRITE: 5 cycles, one digit per cycle, MS digit first. Then return to IDLE.
- Saturation: a captured value >99999 is replaced by 99999 before conversion. The comparison is done on the full DATA_W width.
- Arbitration is round-robin on a last_grant bit, updated on every grant.
  - Only one req high: that requester is granted.
  - Both high: the requester not granted last time wins.
  - Reset value of last_grant = distance, so speed wins the first tie.
- A req that rises while busy is held pending. It is evaluated at the next IDLE cycle. A requester never loses its req.
- Requesters must drop req in the cycle after seeing ack. req still high in the first IDLE cycle after completion is treated as a new request.
- No read-back. sh_ram contents are not cleared by this block.

## Timing
- Edge E0 samples req in IDLE. The following cycles C1, C2, … are relative to E0.
- C1: ack high for exactly one cycle; busy high from C1.
- E1–E17: 17 conversion shifts.
- C18–C22: wr_en=1, wr_addr=base+0…base+4, wr_data valid in the same cycle as wr_en.
- E22: return to IDLE.
- C23: busy=0; a pending req is sampled at E23.
- Fixed latency: 23 cycles per update; maximum update rate is one per 23 cycles.
- wr_en, wr_addr and wr_data are registered. wr_addr and wr_data are 0 whenever wr_en=0.
- Reset (asynchronous, any time):
  - state=IDLE, spd_ack=0, dst_ack=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, last_grant=distance.
  - The conversion in flight is aborted; no further writes from it.
  - Digits already written remain in sh_ram.
- After deassertion, the first clk edge can sample req.

## Configuration
- SH_RAM_BLANK_EN defined: leading-zero blanking.
  - Leading zero digits of a group are written as 4'hF (blank glyph).
  - The units digit (base+4) is always numeric, so value 0 shows F,F,F,F,0.
  - Blanking is decided during WRITE from already-written digits only; latency is unchanged.
- SH_RAM_BLANK_EN undefined: all five digits are written numerically, including leading zeros.

## Test plan
- Reset mid-idle and mid-CONV: all outputs read 0 immediately and asynchronously. No wr_en is seen afterwards until a new req.
- spd_val=345, spd_req at E0 (macro off):
  - spd_ack in C1.
  - C18–C22 writes addr5=0, addr6=0, addr7=3, addr8=4, addr9=5.
  - busy low in C23.
- dst_val=123456: saturation, addr 0–4 written 9,9,9,9,9.
- dst_val=99999: addr 0–4 written 9,9,9,9,9.
- dst_val=0: addr 0–4 written 0,0,0,0,0.
- spd_req and dst_req both held high from reset, each dropped after its ack:
  - speed granted at E0, writes in C18–C22.
  - dst_ack in C24; distance writes addr 0–4 in C41–C45.
  - Repeating the tie then grants speed (alternation).
- spd_req asserted at C5 during a distance conversion: distance writes are unaffected, then speed is granted at E23.
- SH_RAM_BLANK_EN defined:
  - spd_val=7 writes F,F,F,F,7.
  - spd_val=0 writes F,F,F,F,0.
  - spd_val=10203 writes 1,0,2,0,3 (interior zeros are not blanked).
